// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad scanner: command codes,
// the 4x4 key map, the scanner state encoding and small helpers.
package calc_pkg;

    localparam logic [3:0] CMD_0    = 4'h0;
    localparam logic [3:0] CMD_1    = 4'h1;
    localparam logic [3:0] CMD_2    = 4'h2;
    localparam logic [3:0] CMD_3    = 4'h3;
    localparam logic [3:0] CMD_4    = 4'h4;
    localparam logic [3:0] CMD_5    = 4'h5;
    localparam logic [3:0] CMD_6    = 4'h6;
    localparam logic [3:0] CMD_7    = 4'h7;
    localparam logic [3:0] CMD_8    = 4'h8;
    localparam logic [3:0] CMD_9    = 4'h9;
    localparam logic [3:0] CMD_ADD  = 4'hA;
    localparam logic [3:0] CMD_SUB  = 4'hB;
    localparam logic [3:0] CMD_MUL  = 4'hC;
    localparam logic [3:0] CMD_CLR  = 4'hD;
    localparam logic [3:0] CMD_EQ   = 4'hE;
    localparam logic [3:0] CMD_IDLE = 4'hF;

    // Indexed KEY_MAP[row][col]; r3/c3 is the unassigned key.
    localparam logic [3:0][3:0][3:0] KEY_MAP = {
        {CMD_IDLE, CMD_EQ,  CMD_0,  CMD_CLR},
        {CMD_MUL,  CMD_9,   CMD_8,  CMD_7},
        {CMD_SUB,  CMD_6,   CMD_5,  CMD_4},
        {CMD_ADD,  CMD_3,   CMD_2,  CMD_1}
    };

    localparam logic [1:0] NONE_ROW = 2'd3;
    localparam logic [1:0] NONE_COL = 2'd3;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESS,
        ST_WAIT_RELEASE
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic one_low(input logic [3:0] rows);
        return rows inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
    endfunction

    function automatic logic [1:0] row_of(input logic [3:0] rows);
        case (rows)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/calc_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
module calc_sync #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: non-blocking so the second stage takes the first stage's pre-edge value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/calc_keypad.sv
// 4x4 keypad scanner: column scan, press/release debounce and a fixed-width
// registered command pulse toward the calculator core.
module calc_keypad
    import calc_pkg::*;
#(
    parameter int         SCAN_DIV        = 4,
    parameter int         DEBOUNCE_CYCLES = 8,
    parameter int         HOLD_CYCLES     = 10,
    parameter logic [3:0] IDLE_CMD        = 4'hF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] cmd,
    output logic       cmd_valid
);

    localparam int CNT_MAX = max3(SCAN_DIV, DEBOUNCE_CYCLES, HOLD_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    // rows_s lags a column change by the synchronizer depth; needs SCAN_DIV >= 3.
    localparam logic [CNT_W-1:0] SETTLE    = CNT_W'(2);

    logic [3:0]       rows_s;
    state_e           state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       pat_q, pat_d;
    logic             armed_q, armed_d;
    logic             clean_q, clean_d;
    logic [3:0]       cmd_q, cmd_d;
    logic             valid_q, valid_d;
    logic [1:0]       key_row;
    logic             sample_ok;

    calc_sync #(.WIDTH(4), .RESET_VAL(4'hF)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (row_n),
        .q     (rows_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_SCAN;
            col_q   <= 2'd0;
            cnt_q   <= '0;
            pat_q   <= 4'hF;
            armed_q <= 1'b0;
            clean_q <= 1'b1;
            cmd_q   <= IDLE_CMD;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            armed_q <= armed_d;
            clean_q <= clean_d;
            cmd_q   <= cmd_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        pat_d     = pat_q;
        armed_d   = armed_q;
        clean_d   = clean_q;
        key_row   = row_of(pat_q);
        sample_ok = (cnt_q >= SETTLE);

        case (state_q)
            ST_SCAN: begin
                if (sample_ok && rows_s != 4'hF) clean_d = 1'b0;
                // Until one clean rotation is seen, a key held across reset is only waited out.
                if (sample_ok && one_low(rows_s)) begin
                    pat_d   = rows_s;
                    cnt_d   = '0;
                    state_d = armed_q ? ST_DEBOUNCE : ST_WAIT_RELEASE;
                end else if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    col_d = col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        armed_d = armed_q | clean_d;
                        clean_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (rows_s != pat_q) begin
                    state_d = ST_SCAN;
                    col_d   = col_q + 2'd1;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    state_d = (key_row == NONE_ROW && col_q == NONE_COL) ? ST_WAIT_RELEASE : ST_PRESS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PRESS: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_RELEASE: begin
                if (rows_s != 4'hF) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                    col_d   = col_q + 2'd1;
                    armed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_SCAN;
        endcase

        valid_d = (state_d == ST_PRESS);
        cmd_d   = valid_d ? KEY_MAP[key_row][col_q] : IDLE_CMD;
    end

    assign col_n     = ~(4'b0001 << col_q);
    assign cmd       = cmd_q;
    assign cmd_valid = valid_q;

endmodule

// File: tb/tb_calc_keypad.sv
// Randomized scoreboard bench for calc_keypad with a behavioural keypad,
// key-map and calculator model.
module tb_calc_keypad;

    logic       clock;
    logic       reset;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] cmd;
    logic       cmd_valid;

    calc_keypad dut (
        .clock     (clock),
        .reset     (reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .cmd       (cmd),
        .cmd_valid (cmd_valid)
    );

    localparam int LATENCY = 11;
    localparam int HOLD    = 10;

    typedef struct {
        logic [3:0] code;
        int         press;
        int         width;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] key_down [4];
    int         cyc;
    int         n_checks;
    int         n_fail;

    int         calc_cur, calc_acc, calc_disp;
    logic [3:0] calc_op;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Physical keypad: a closed switch pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_down[r][c] && !col_n[c]) row_n[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    function automatic logic [3:0] model_code(input int r, input int c);
        string layout;
        byte   ch;
        layout = "123A456B789CD0E?";
        ch = layout[r*4 + c];
        if (ch >= "0" && ch <= "9") return 4'(ch - "0");
        return 4'(ch - "A" + 10);
    endfunction

    task automatic calc_feed(input logic [3:0] k);
        if (k <= 4'd9) begin
            calc_cur  = calc_cur * 10 + int'(k);
            calc_disp = calc_cur;
        end else if (k == 4'hA || k == 4'hB || k == 4'hC) begin
            calc_acc = calc_cur;
            calc_op  = k;
            calc_cur = 0;
        end else if (k == 4'hD) begin
            calc_cur  = 0;
            calc_acc  = 0;
            calc_disp = 0;
        end else if (k == 4'hE) begin
            case (calc_op)
                4'hA:    calc_disp = calc_acc + calc_cur;
                4'hB:    calc_disp = calc_acc - calc_cur;
                4'hC:    calc_disp = calc_acc * calc_cur;
                default: calc_disp = calc_cur;
            endcase
            calc_cur = calc_disp;
        end
    endtask

    // Monitor: pops the scoreboard on every cmd_valid rise and checks the pulse.
    logic mon_prev = 1'b0;
    logic mon_active = 1'b0;
    logic mon_stable;
    int   mon_width;
    exp_t mon_exp;

    always @(negedge clock) begin
        if (cmd_valid && !mon_prev) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got cmd %0h, expected no pulse (cycle %0d)", cmd, cyc);
                mon_active = 1'b0;
            end else begin
                mon_exp    = sb_q.pop_front();
                mon_active = 1'b1;
                mon_width  = 0;
                mon_stable = 1'b1;
                check("pulse_code", 32'(cmd), 32'(mon_exp.code));
                if (mon_exp.press >= 0) check("pulse_latency", cyc - mon_exp.press, LATENCY);
                calc_feed(cmd);
            end
        end
        if (cmd_valid) begin
            mon_width++;
            if (mon_active && cmd !== mon_exp.code) mon_stable = 1'b0;
        end
        if (!cmd_valid && mon_prev && mon_active) begin
            check("pulse_width", mon_width, mon_exp.width);
            check("pulse_cmd_stable", 32'(mon_stable), 32'd1);
            check("cmd_idle_after_pulse", 32'(cmd), 32'hF);
            mon_active = 1'b0;
        end
        mon_prev = cmd_valid;
    end

    task automatic wait_fresh_col(input int c, output bit ok);
        logic [3:0] prev;
        logic [3:0] tgt;
        tgt  = ~(4'b0001 << c);
        ok   = 1'b0;
        prev = col_n;
        for (int i = 0; i < 300; i++) begin
            @(posedge clock);
            #1;
            if (col_n != prev && col_n == tgt) begin
                ok = 1'b1;
                break;
            end
            prev = col_n;
        end
    endtask

    task automatic press_key(input int r, input int c, input int hold, input bit expect_pulse);
        bit ok;
        wait_fresh_col(c, ok);
        if (!ok) begin
            timeout_fail("column_wait");
            return;
        end
        if (expect_pulse) sb_q.push_back('{code: model_code(r, c), press: cyc, width: HOLD});
        key_down[r][c] = 1'b1;
        repeat (hold) @(posedge clock);
        #1 key_down[r][c] = 1'b0;
    endtask

    initial begin
        bit         ok;
        int         r, c, changes;
        logic [3:0] prev;

        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        calc_cur = 0;
        calc_acc = 0;
        calc_disp = 0;
        calc_op  = 4'h0;
        for (int i = 0; i < 4; i++) key_down[i] = 4'h0;
        reset = 1'b1;

        #1;
        check("reset_col_n", 32'(col_n), 32'b1110);
        check("reset_cmd", 32'(cmd), 32'hF);
        check("reset_cmd_valid", 32'(cmd_valid), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (30) @(posedge clock);

        // Single key "2" held well past the pulse: one pulse only.
        press_key(0, 1, 40, 1'b1);
        repeat (30) @(posedge clock);

        // Calculator sequence 1 2 C 3 E -> 36.
        calc_cur = 0; calc_acc = 0; calc_disp = 0; calc_op = 4'h0;
        press_key(0, 0, 30, 1'b1); repeat (30) @(posedge clock);
        press_key(0, 1, 30, 1'b1); repeat (30) @(posedge clock);
        press_key(2, 3, 30, 1'b1); repeat (30) @(posedge clock);
        press_key(0, 2, 30, 1'b1); repeat (30) @(posedge clock);
        press_key(3, 2, 30, 1'b1); repeat (30) @(posedge clock);
        check("calc_display", calc_disp, 36);

        // Randomized presses, some released while the pulse is still running.
        for (int n = 0; n < 12; n++) begin
            do begin
                r = int'($urandom_range(0, 3));
                c = int'($urandom_range(0, 3));
            end while (r == 3 && c == 3);
            press_key(r, c, int'($urandom_range(12, 40)), 1'b1);
            repeat ($urandom_range(0, 20)) @(posedge clock);
        end
        repeat (20) @(posedge clock);

        // Bouncing "4": one pulse once the contact settles.
        wait_fresh_col(0, ok);
        if (!ok) timeout_fail("bounce_column_wait");
        sb_q.push_back('{code: 4'h4, press: -1, width: HOLD});
        for (int i = 0; i < 20; i++) begin
            key_down[1][0] = ((i / 3) % 2 == 0);
            @(posedge clock);
            #1;
        end
        key_down[1][0] = 1'b1;
        repeat (45) @(posedge clock);
        #1 key_down[1][0] = 1'b0;
        repeat (30) @(posedge clock);

        // Ghost: two rows low on column 2 is ignored and scanning keeps rotating.
        key_down[0][2] = 1'b1;
        key_down[2][2] = 1'b1;
        @(negedge clock);
        prev    = col_n;
        changes = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (col_n != prev) begin
                check("ghost_rotation", 32'(col_n), 32'({prev[2:0], prev[3]}));
                changes++;
            end
            prev = col_n;
        end
        check("ghost_keeps_scanning", 32'(changes >= 8), 32'd1);
        key_down[0][2] = 1'b0;
        key_down[2][2] = 1'b0;
        repeat (20) @(posedge clock);

        // Unassigned key r3/c3: no pulse, column frozen until release + 8 clean cycles.
        press_key(3, 3, 40, 1'b0);
        check("none_key_frozen_at_release", 32'(col_n), 32'b0111);
        repeat (9) @(posedge clock);
        #1 check("none_key_still_frozen", 32'(col_n), 32'b0111);
        @(posedge clock);
        #1 check("none_key_scan_resumes", 32'(col_n), 32'b1110);
        repeat (20) @(posedge clock);

        // Reset in cycle 5 of a "5" pulse; the held key must not re-fire.
        wait_fresh_col(1, ok);
        if (!ok) timeout_fail("reset_column_wait");
        sb_q.push_back('{code: 4'h5, press: cyc, width: 4});
        key_down[1][1] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (cmd_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("reset_pulse_wait");
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("reset_mid_press_valid", 32'(cmd_valid), 32'd0);
        check("reset_mid_press_col_n", 32'(col_n), 32'b1110);
        check("reset_mid_press_cmd", 32'(cmd), 32'hF);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (60) @(posedge clock);
        #1 key_down[1][1] = 1'b0;
        repeat (20) @(posedge clock);
        press_key(1, 1, 25, 1'b1);

        repeat (50) @(posedge clock);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
